// File: rtl/sqrt_host.sv
// Host sequencer for the iterative sqrt core: operand FIFO, issue/collect FSM, result register.
// Optional WAIT watchdog with sticky error and terminal ERR state: define SQRT_HOST_TIMEOUT_EN.
module sqrt_host #(
    parameter int unsigned IL      = 8,
    parameter int unsigned FL      = 12,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 63,
    localparam int unsigned W      = IL + FL,
    localparam int unsigned CW     = $clog2(DEPTH + 1),
    localparam int unsigned PW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [W-1:0]  core_in,
    output logic          core_input_ready,
    output logic          core_output_taken,
    input  logic [1:0]    core_state,
    input  logic [W-1:0]  core_out,
    output logic [W-1:0]  m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          error
);

    localparam logic [1:0] CoreIdle = 2'b00;
    localparam logic [1:0] CoreDone = 2'b10;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCollect, StErr} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  core_in_q, m_data_q;
    logic          cir_q, cot_q, m_valid_q;
    logic          full, empty, push, pop, slot_free;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = s_valid && s_ready;
    assign pop       = (state_q == StIssue);
    assign slot_free = !m_valid_q || m_ready;

`ifdef SQRT_HOST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q;
    logic          error_q;
    logic          stalled;

    // Backpressure waits are the downstream's fault, not the core's, so they do not count.
    assign stalled = (core_state == CoreDone) && !slot_free;
    assign s_ready = reset && !full && (state_q != StErr);
    assign error   = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign s_ready        = reset && !full;
    assign error          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (!empty && core_state == CoreIdle) state_d = StIssue;
            StIssue:   state_d = StWait;
            StWait: begin
                if (core_state == CoreDone && slot_free) begin
                    state_d = StCollect;
                end
`ifdef SQRT_HOST_TIMEOUT_EN
                else if (!stalled && timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = StErr;
                end
`endif
            end
            StCollect: state_d = StIdle;
`ifdef SQRT_HOST_TIMEOUT_EN
            StErr:     state_d = StErr;
`endif
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            core_in_q <= '0;
            cir_q     <= 1'b0;
            cot_q     <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            // Strobes are registered from the next state so they coincide with ISSUE/COLLECT.
            cir_q <= (state_d == StIssue);
            cot_q <= (state_d == StCollect);
            if (state_d == StIssue) begin
                core_in_q <= mem_q[rd_ptr_q];
            end
            if (state_q == StCollect) begin
                m_data_q  <= core_out;
                m_valid_q <= 1'b1;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

`ifdef SQRT_HOST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (state_q == StIssue) begin
                timer_q <= '0;
            end else if (state_q == StWait && !stalled) begin
                timer_q <= timer_q + TW'(1);
            end
            if (state_d == StErr) begin
                error_q <= 1'b1;
            end
        end
    end
`endif

    assign core_in           = core_in_q;
    assign core_input_ready  = cir_q;
    assign core_output_taken = cot_q;
    assign m_data            = m_data_q;
    assign m_valid           = m_valid_q;
    assign count             = count_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_sqrt_host.sv
// Bench for sqrt_host with a behavioural integer-sqrt core model and a result scoreboard.
// The watchdog scenario runs only when SQRT_HOST_TIMEOUT_EN is defined.
module tb_sqrt_host;

    localparam int unsigned IL      = 8;
    localparam int unsigned FL      = 12;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 63;
    localparam int unsigned W       = IL + FL;
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam int          LAT     = 4;

    logic          clk, reset;
    logic [W-1:0]  s_data;
    logic          s_valid, s_ready;
    logic [W-1:0]  core_in;
    logic          core_input_ready, core_output_taken;
    logic [1:0]    core_state;
    logic [W-1:0]  core_out;
    logic [W-1:0]  m_data;
    logic          m_valid, m_ready;
    logic [CW-1:0] count;
    logic          busy, error;

    sqrt_host #(.IL(IL), .FL(FL), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .core_in           (core_in),
        .core_input_ready  (core_input_ready),
        .core_output_taken (core_output_taken),
        .core_state        (core_state),
        .core_out          (core_out),
        .m_data            (m_data),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .count             (count),
        .busy              (busy),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] v);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return W'(r);
    endfunction

    // Core model: 00 idle, 01 busy for LAT+1 cycles, 10 holding result until taken.
    logic         stuck;
    logic [W-1:0] core_op;
    int           core_cnt;
    always @(posedge clk) begin
        if (!reset) begin
            core_state <= 2'b00;
            core_out   <= '0;
            core_cnt   <= 0;
        end else begin
            case (core_state)
                2'b00: if (core_input_ready) begin
                    core_op    <= core_in;
                    core_cnt   <= LAT;
                    core_state <= 2'b01;
                end
                2'b01: if (!stuck) begin
                    if (core_cnt == 0) begin
                        core_out   <= isqrt(core_op);
                        core_state <= 2'b10;
                    end else begin
                        core_cnt <= core_cnt - 1;
                    end
                end
                2'b10: if (core_output_taken) core_state <= 2'b00;
                default: core_state <= 2'b00;
            endcase
        end
    end

    // Output monitor and protocol observers, sampled mid-cycle.
    int   cyc = 0, ir_pulses = 0, ir_wide = 0, bp_viol = 0, out_cnt = 0;
    int   last_cot = -1, last_gap = -1;
    logic prev_ir = 1'b0;
    always @(negedge clk) begin
        logic [W-1:0] e;
        cyc++;
        if (core_input_ready === 1'b1) begin
            ir_pulses++;
            if (prev_ir) ir_wide++;
            if (last_cot >= 0) last_gap = cyc - last_cot;
        end
        prev_ir = (core_input_ready === 1'b1);
        if (core_output_taken === 1'b1) begin
            last_cot = cyc;
            if (m_valid && !m_ready) bp_viol++;
        end
        if (reset && m_valid === 1'b1 && m_ready) begin
            vectors++;
            out_cnt++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: got m_data=%h with empty scoreboard", m_data);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    miscompares++;
                    $display("FAIL result_data: got %h want %h", m_data, e);
                end
            end
        end
    end

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_op(input logic [W-1:0] v, input logic [W-1:0] e);
        s_data  = v;
        s_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_ready) begin
                exp_q.push_back(e);
                cyc_step();
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        vectors++;
        miscompares++;
        $display("FAIL push_timeout: s_ready=%b want 1", s_ready);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !m_valid && !busy) break;
            cyc_step();
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending results want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({s_ready, m_valid, busy, core_input_ready, core_output_taken, error} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000",
                     {s_ready, m_valid, busy, core_input_ready, core_output_taken, error});
        end
        vectors++;
        if (count !== '0 || core_in !== '0 || m_data !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: got count=%0d core_in=%h m_data=%h want 0 0 0",
                     count, core_in, m_data);
        end
        reset = 1'b1;
        cyc_step();
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b want 1", s_ready);
        end
    endtask

    task automatic test_single();
        int t0 = -1, t1 = -1;
        m_ready = 1'b1;
        push_op(20'h04000, 20'h00080);
        vectors++;
        if (count !== CW'(1) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL count_after_push: got count=%0d busy=%b want 1 0", count, busy);
        end
        cyc_step();
        vectors++;
        if (core_input_ready !== 1'b1 || core_in !== 20'h04000) begin
            miscompares++;
            $display("FAIL issue: got ir=%b core_in=%h want 1 04000", core_input_ready, core_in);
        end
        for (int i = 0; i < 100 && t1 < 0; i++) begin
            if (t0 < 0 && core_state == 2'b10) t0 = i;
            if (m_valid === 1'b1) t1 = i;
            cyc_step();
        end
        vectors++;
        if (t0 < 0 || t1 - t0 != 2) begin
            miscompares++;
            $display("FAIL result_latency: got %0d cycles want 2", t1 - t0);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ops [4] = '{20'h00019, 20'h00064, 20'h00090, 20'h00000};
        logic [W-1:0] res [4] = '{20'h00005, 20'h0000A, 20'h0000C, 20'h00000};
        int p0 = ir_pulses, w0 = ir_wide;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_op(ops[i], res[i]);
        wait_drain();
        vectors++;
        if (ir_pulses - p0 != 4 || ir_wide != w0) begin
            miscompares++;
            $display("FAIL issue_pulses: got %0d pulses %0d wide want 4 0",
                     ir_pulses - p0, ir_wide - w0);
        end
        vectors++;
        if (last_gap != 2) begin
            miscompares++;
            $display("FAIL reissue_gap: got %0d want 2", last_gap);
        end
    endtask

    task automatic test_fifo_full();
        int o0 = out_cnt;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) push_op(W'((i + 3) * (i + 3)), W'(i + 3));
        repeat (3) cyc_step();
        vectors++;
        if (count !== CW'(DEPTH) || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full: got count=%0d s_ready=%b want %0d 0", count, s_ready, DEPTH);
        end
        vectors++;
        if (m_valid !== 1'b1 || core_output_taken !== 1'b0 || bp_viol != 0) begin
            miscompares++;
            $display("FAIL stall: got m_valid=%b taken=%b viol=%0d want 1 0 0",
                     m_valid, core_output_taken, bp_viol);
        end
        m_ready = 1'b1;
        wait_drain();
        vectors++;
        if (out_cnt - o0 != DEPTH + 2) begin
            miscompares++;
            $display("FAIL full_drain_count: got %0d want %0d", out_cnt - o0, DEPTH + 2);
        end
    endtask

    task automatic test_simultaneous();
        m_ready = 1'b1;
        s_data  = 20'h00031;
        s_valid = 1'b1;
        exp_q.push_back(20'h00007);
        cyc_step();
        s_valid = 1'b0;
        cyc_step();
        vectors++;
        if (core_input_ready !== 1'b1 || count !== CW'(1)) begin
            miscompares++;
            $display("FAIL pop_cycle: got ir=%b count=%0d want 1 1", core_input_ready, count);
        end
        s_data  = 20'h00051;
        s_valid = 1'b1;
        exp_q.push_back(20'h00009);
        cyc_step();
        s_valid = 1'b0;
        vectors++;
        if (count !== CW'(1)) begin
            miscompares++;
            $display("FAIL push_pop_count: got %0d want 1", count);
        end
        wait_drain();
        // Hold one result downstream while the next is ready in the core, then release.
        m_ready = 1'b0;
        push_op(20'h00040, 20'h00008);
        push_op(20'h00079, 20'h0000B);
        for (int i = 0; i < 60 && !(m_valid && core_state == 2'b10); i++) cyc_step();
        cyc_step();
        vectors++;
        if (core_output_taken !== 1'b0 || m_data !== 20'h00008) begin
            miscompares++;
            $display("FAIL held: got taken=%b m_data=%h want 0 00008", core_output_taken, m_data);
        end
        m_ready = 1'b1;
        cyc_step();
        vectors++;
        if (core_output_taken !== 1'b1) begin
            miscompares++;
            $display("FAIL collect_on_release: got %b want 1", core_output_taken);
        end
        cyc_step();
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 20'h0000B) begin
            miscompares++;
            $display("FAIL reload: got m_valid=%b m_data=%h want 1 0000B", m_valid, m_data);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int o0;
        m_ready = 1'b1;
        push_op(20'h00100, 20'h00010);
        push_op(20'h00200, 20'h00016);
        push_op(20'h00300, 20'h0001B);
        for (int i = 0; i < 40 && !(core_state == 2'b01 && count == CW'(2)); i++) cyc_step();
        o0 = out_cnt;
        reset = 1'b0;
        exp_q.delete();
        cyc_step();
        vectors++;
        if (count !== '0 || m_valid !== 1'b0 || busy !== 1'b0 || core_input_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got count=%0d m_valid=%b busy=%b ir=%b want 0 0 0 0",
                     count, m_valid, busy, core_input_ready);
        end
        reset = 1'b1;
        repeat (40) cyc_step();
        vectors++;
        if (out_cnt != o0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_result: got %0d outputs m_valid=%b want 0 0", out_cnt - o0, m_valid);
        end
    endtask

`ifdef SQRT_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        m_ready = 1'b1;
        stuck   = 1'b1;
        push_op(20'h00400, 20'h00020);
        for (int i = 0; i < 10 && core_input_ready !== 1'b1; i++) cyc_step();
        for (int i = 0; i < TIMEOUT + 20 && error !== 1'b1; i++) begin
            cyc_step();
            n++;
        end
        vectors++;
        if (n != TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT + 1);
        end
        repeat (3) cyc_step();
        vectors++;
        if (error !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL err_state: got error=%b s_ready=%b busy=%b want 1 0 1",
                     error, s_ready, busy);
        end
        reset = 1'b0;
        exp_q.delete();
        cyc_step();
        stuck = 1'b0;
        reset = 1'b1;
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL error_clear: got %b want 0", error);
        end
        cyc_step();
    endtask
`endif

    initial begin
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        stuck   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_simultaneous();
        test_reset_mid();
`ifdef SQRT_HOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
